// File: rtl/regbus_apb_master.sv
// regbus_apb_master: bridges a single-outstanding register request channel
// onto an APB3/APB4 SETUP/ACCESS transfer and returns the result on a
// response channel. Hung transfers are aborted after TIMEOUT ACCESS cycles.
//
// Handshakes (req_*, rsp_*): a transfer happens on a rising clock edge where
// vld && rdy are both high. The source holds vld and its payload stable until
// that edge. The sink may raise or lower rdy at any time. Here, req_rdy is
// high only in IDLE and rsp_vld only in RESP. Both are registers, so neither
// depends combinationally on the other side.
module regbus_apb_master #(
    parameter int         ADDR_WIDTH = 16,
    parameter int         DATA_WIDTH = 32,
    parameter int         TIMEOUT    = 16,
    parameter logic [2:0] PROT       = 3'b000
) (
    input  logic                      clk,
    input  logic                      rst,
    // request channel
    input  logic                      req_vld,
    output logic                      req_rdy,
    input  logic                      req_write,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    input  logic [DATA_WIDTH/8-1:0]   req_strb,
    // response channel
    output logic                      rsp_vld,
    input  logic                      rsp_rdy,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic                      rsp_err,
    output logic                      rsp_timeout,
    output logic [7:0]                err_cnt,
    // APB master port
    output logic [ADDR_WIDTH-1:0]     p_addr,
    output logic [2:0]                p_prot,
    output logic                      p_sel,
    output logic                      p_enable,
    output logic                      p_write,
    output logic [DATA_WIDTH-1:0]     p_wdata,
    output logic [DATA_WIDTH/8-1:0]   p_strb,
    input  logic                      p_ready,
    input  logic [DATA_WIDTH-1:0]     p_rdata,
    input  logic                      p_slverr,
    // current FSM state, for observation only
    output logic [1:0]                state_dbg
);

    localparam int                   STRB_WIDTH = DATA_WIDTH / 8;
    // Wide enough to hold TIMEOUT-1. It is never narrower than one bit.
    localparam int                   CNT_WIDTH  = $clog2(TIMEOUT + 2);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST   = CNT_WIDTH'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] wait_cnt;

    assign p_prot    = PROT;
    assign state_dbg = state;

    // Transfer sequencer. Every output is a register updated on the state transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            req_rdy     <= 1'b1;
            rsp_vld     <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            err_cnt     <= '0;
            p_addr      <= '0;
            p_sel       <= 1'b0;
            p_enable    <= 1'b0;
            p_write     <= 1'b0;
            p_wdata     <= '0;
            p_strb      <= '0;
            wait_cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_vld && req_rdy) begin
                        p_addr  <= req_addr;
                        p_write <= req_write;
                        p_wdata <= req_wdata;
                        // A read carries no byte lanes.
                        p_strb  <= req_write ? req_strb : {STRB_WIDTH{1'b0}};
                        p_sel   <= 1'b1;
                        req_rdy <= 1'b0;
                        state   <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    // p_ready has no meaning before ACCESS and is ignored here.
                    p_enable <= 1'b1;
                    wait_cnt <= '0;
                    state    <= S_ACCESS;
                end

                S_ACCESS: begin
                    if (p_ready) begin
                        // A completion in the last allowed cycle still counts as completion.
                        rsp_rdata   <= (!p_write && !p_slverr) ? p_rdata : '0;
                        rsp_err     <= p_slverr;
                        rsp_timeout <= 1'b0;
                        rsp_vld     <= 1'b1;
                        p_sel       <= 1'b0;
                        p_enable    <= 1'b0;
                        state       <= S_RESP;
                    end else if ((TIMEOUT != 0) && (wait_cnt == CNT_LAST)) begin
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_vld     <= 1'b1;
                        p_sel       <= 1'b0;
                        p_enable    <= 1'b0;
                        state       <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                S_RESP: begin
                    if (rsp_vld && rsp_rdy) begin
                        if (rsp_err && (err_cnt != 8'hFF)) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
                        rsp_vld <= 1'b0;
                        req_rdy <= 1'b1;
                        state   <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
